led_step_ctrl: RTL

- Control front-end that sits directly upstream of the LED pattern generators (shift/fill, left/right, in/out families).
- Debounces three push-buttons: run, mode and speed.
- Holds the run/pause and direction state, and produces a one-cycle advance pulse at a selectable rate.
- Pattern generators run on the fast system clock with their SS input tied to adv and MODE tied to mode, so each adv pulse moves the pattern one step.

---
 rtl/led_step_ctrl.sv | 71 +++++++
 1 files changed

// File: rtl/led_step_ctrl.sv
// led_step_ctrl: debounced run/mode/speed buttons driving a rate-selectable one-cycle step pulse
module led_step_ctrl #(
    parameter int STEP_DIV  = 25_000_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_run,
    input  logic       btn_mode,
    input  logic       btn_speed,
    output logic       run,
    output logic       mode,
    output logic [1:0] speed,
    output logic       adv
);
    localparam int DW = $clog2(DB_CYCLES);
    localparam int CW = $clog2(STEP_DIV);
    localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] L0 = CW'(STEP_DIV - 1);
    localparam logic [CW-1:0] L1 = CW'(STEP_DIV / 2 - 1);
    localparam logic [CW-1:0] L2 = CW'(STEP_DIV / 4 - 1);
    localparam logic [CW-1:0] L3 = CW'(STEP_DIV / 8 - 1);
    logic [2:0] btn, s1, s2, db, hit, press;
    logic [DW-1:0] dcnt [3];
    logic [CW-1:0] cnt, last;
    assign btn   = {btn_speed, btn_mode, btn_run};
    assign press = hit & s2;
    always_comb begin
        hit = '0;
        for (int k = 0; k < 3; k++)
            hit[k] = (s2[k] != db[k]) && (dcnt[k] == DB_LAST);
        last = speed == 2'd0 ? L0 : speed == 2'd1 ? L1 : speed == 2'd2 ? L2 : L3;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            db <= '0;
            for (int k = 0; k < 3; k++)
                dcnt[k] <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            db <= db ^ hit;
            for (int k = 0; k < 3; k++)
                dcnt[k] <= (s2[k] == db[k] || hit[k]) ? '0 : dcnt[k] + DW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            run   <= 1'b0;
            mode  <= 1'b0;
            speed <= 2'd0;
            cnt   <= '0;
            adv   <= 1'b0;
        end else begin
            run  <= run ^ press[0];
            mode <= mode ^ press[1];
            if (press[2]) begin
                speed <= speed + 2'd1;
                cnt   <= '0;
                adv   <= 1'b0;
            end else if (run) begin
                cnt <= (cnt == last) ? '0 : cnt + CW'(1);
                adv <= (cnt == last);
            end else begin
                adv <= 1'b0;
            end
        end
    end
endmodule
